mips_cpu_muldiv_seq: RTL and testbench
======================================

# mips_cpu_muldiv_seq

Parametrised sequential multiply/divide unit owning the HI/LO register pair for the multicycle MIPS core. It executes MULT, MULTU, DIV and DIVU iteratively over several cycles, and MTHI/MTLO in a single cycle, behind a start/ready/done handshake. The core's DECODE state stalls on `ready`/`done` rather than on ad-hoc divider flags. It adds features the current HI/LO block lacks: configurable width and bits-per-cycle, iterative multiply, divide-by-zero reporting, and result staging so HI/LO never show partial values.

## Interface
- `WIDTH`, 32, operand and HI/LO width; must be even.
- `STEP`, 1, quotient/multiplier bits retired per cycle; one of 1, 2, 4; `WIDTH % STEP == 0`.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted on a rising edge where `start && ready`.
- `op`  in  3  `muldiv_op_t`: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- `a`  in  WIDTH  rs operand (dividend, multiplicand, or MTHI/MTLO source).
- `b`  in  WIDTH  rt operand (divisor, multiplier); ignored for MTHI/MTLO.
- `ready`  out  1  high only in IDLE.
- `done`  out  1  one-cycle pulse; HI/LO are final in the same cycle.
- `div_by_zero`  out  1  pulses with `done` when a DIV/DIVU had `b == 0`.
- `hi`  out  WIDTH  architectural HI.
- `lo`  out  WIDTH  architectural LO.

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- On reset:
  - state goes to IDLE.
  - `hi`, `lo`, `done`, `div_by_zero` and all working registers go to 0.
  - Reset mid-operation abandons the operation; no HI/LO update occurs.
- IDLE with start and MULT/MULTU/DIV/DIVU:
  - latch `op`, the operand magnitudes (signed ops use |a|, |b|), the sign flags, and a step counter = WIDTH/STEP.
  - go to CALC.
- IDLE with start and DIV/DIVU with `b == 0`:
  - go directly to DONE with `div_by_zero` set.
  - `hi`/`lo` keep their previous values.
- IDLE with start and MTHI/MTLO:
  - write `a` into `hi`/`lo` at the accepting edge.
  - go to DONE.
- `start` while not ready is ignored and not queued. `a`, `b` and `op` need only be valid in the accepting cycle.
- CALC, multiply: shift-add over a 2·WIDTH accumulator, STEP multiplier bits per cycle.
- CALC, divide: restoring division, STEP quotient bits per cycle, with WIDTH+1-bit partial-remainder subtract.
- The counter decrements each CALC cycle; at 1, go to FIXUP.
- FIXUP: apply sign correction and commit results to `hi`/`lo` at the edge, then go to DONE.
  - MULT: 2·WIDTH product, negated if the operand signs differ.
  - Product commit: `hi` = upper half, `lo` = lower half.
  - DIV quotient: negated if the signs differ.
  - DIV remainder: takes the sign of the dividend.
  - Division commit: `lo` = quotient, `hi` = remainder.
  - Overflow case, DIV 0x80000000 / 0xFFFFFFFF: `lo` = 0x80000000, `hi` = 0, no flag.
- DONE: `done` = 1 (plus `div_by_zero` if set); go to IDLE next edge and clear the flags.
- `hi`/`lo` hold their old values throughout CALC. The core must not issue MFHI/MFLO until `ready`.

## Timing
- Arithmetic op accepted at edge E0: CALC covers cycles 1..N, where N = WIDTH/STEP.
- Arithmetic FIXUP is in cycle N+1; `done` is high in cycle N+2; `ready` is high again in cycle N+3.
- WIDTH=32, STEP=1: `done` 34 cycles after acceptance; the next start is accepted in cycle 35.
- MTHI/MTLO and divide-by-zero: `done` in cycle 1; `ready` in cycle 2.
- `ready` is a registered-state decode with no combinational path from `start`.
- `hi`/`lo` are direct register outputs.

## Structure
- A `mips_cpu_muldiv_pkg` package holds:
  - the `muldiv_op_t` enum: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5;
  - the state enum;
  - a helper function for two's-complement magnitude.
- One sub-module, `mips_cpu_divstep`, is combinational: one restoring-division step (remainder, divisor → new remainder, quotient bit).
  - It is instantiated STEP times in a chain.
  - The multiply path stays inline.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> `done` at cycle 34; `hi`=0xFFFFFFFE, `lo`=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=5 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- DIV a=-7, b=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU a=7, b=0 with `hi`/`lo` preset by MTHI/MTLO to 0x11/0x22 -> `done` and `div_by_zero` at cycle 1; `hi`/`lo` unchanged.
- DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0; `start` held high during CALC is ignored.
- Reset asserted in CALC cycle 10 of a DIVU -> IDLE and `ready`=1 next cycle, `hi`=`lo`=0, no `done`.
- Rerun the first three scenarios at STEP=4 with `done` at cycle 10; rerun at WIDTH=16.

Source files
------------

// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared types for the sequential multiply/divide unit.
// Op codes, FSM states and a magnitude helper.
package mips_cpu_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIXUP,
    S_DONE
  } md_state_t;

  localparam int MAG_W = 64;

  // Two's-complement magnitude of a sign-extended value.
  function automatic logic [MAG_W-1:0] mag(
    input logic [MAG_W-1:0] v
  );
    return v[MAG_W-1] ? (~v + MAG_W'(1)) : v;
  endfunction

endpackage

// File: rtl/mips_cpu_divstep.sv
// One restoring-division step.
// Shifts in a dividend bit and subtracts the divisor if it fits.
import mips_cpu_muldiv_pkg::*;

module mips_cpu_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_in < divisor, so diff[WIDTH] alone tells a borrow.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0]
                    : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mips_cpu_muldiv_seq.sv
// Sequential MULT/DIV unit owning HI/LO.
// Iterates STEP bits per cycle; commits HI/LO only at FIXUP.
import mips_cpu_muldiv_pkg::*;

module mips_cpu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);
  localparam int W2 = 2 * WIDTH;

  md_state_t        state, state_nx;
  muldiv_op_t       op_q;
  logic             neg_q, rneg_q, dbz_q;
  logic [CW-1:0]    cnt;
  logic [W2-1:0]    acc;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             is_mul, is_div, is_mt;
  logic             sgn, b_zero, op_mul_q;
  logic [WIDTH-1:0] a_abs, b_abs;

  logic [WIDTH+STEP-1:0] psum;
  logic [W2-1:0]         mul_nx, div_nx, prod;
  logic [WIDTH-1:0]      quo, rem;
  logic [WIDTH-1:0]      fix_hi, fix_lo;
  logic [WIDTH-1:0]      rem_c [0:STEP];
  logic [STEP-1:0]       qb;

  // Decode of the incoming request.
  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    is_mt  = 1'b0;
    sgn    = 1'b0;
    unique case (1'b1)
      op == OP_MULT:  begin is_mul = 1'b1; sgn = 1'b1; end
      op == OP_MULTU: is_mul = 1'b1;
      op == OP_DIV:   begin is_div = 1'b1; sgn = 1'b1; end
      op == OP_DIVU:  is_div = 1'b1;
      op == OP_MTHI,
      op == OP_MTLO:  is_mt = 1'b1;
      default: ;
    endcase
    b_zero = (b == '0);
    a_abs  = sgn ? WIDTH'(mag(MAG_W'($signed(a)))) : a;
    b_abs  = sgn ? WIDTH'(mag(MAG_W'($signed(b)))) : b;
  end

  assign rem_c[0] = acc[W2-1:WIDTH];

  generate
    for (genvar i = 0; i < STEP; i++) begin : g_div
      mips_cpu_divstep #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_c[i]),
        .bit_in  (acc[WIDTH-1-i]),
        .divisor (opb),
        .rem_out (rem_c[i+1]),
        .q_bit   (qb[STEP-1-i])
      );
    end
  endgenerate

  // Per-cycle iteration values and final sign correction.
  always_comb begin
    op_mul_q = (op_q == OP_MULT) || (op_q == OP_MULTU);
    psum   = {{STEP{1'b0}}, acc[W2-1:WIDTH]}
           + ({{STEP{1'b0}}, opb}
              * {{WIDTH{1'b0}}, acc[STEP-1:0]});
    mul_nx = {psum, acc[WIDTH-1:STEP]};
    div_nx = {rem_c[STEP], acc[WIDTH-1-STEP:0], qb};
    prod   = neg_q ? -acc : acc;
    quo    = acc[WIDTH-1:0];
    rem    = acc[W2-1:WIDTH];
    if (op_mul_q) begin
      fix_hi = prod[W2-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end else begin
      fix_hi = rneg_q ? -rem : rem;
      fix_lo = neg_q ? -quo : quo;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (is_mt || (is_div && b_zero))
            state_nx = S_DONE;
          else if (is_mul || is_div)
            state_nx = S_CALC;
        end
      end
      S_CALC:  if (cnt == CW'(1)) state_nx = S_FIXUP;
      S_FIXUP: state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand latch, iteration and HI/LO commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= OP_MULT;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dbz_q  <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start && (is_mul || is_div || is_mt)) begin
            op_q   <= op;
            cnt    <= CW'(N);
            neg_q  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_q <= sgn & a[WIDTH-1];
            dbz_q  <= is_div & b_zero;
            if (is_mul) begin
              acc <= {{WIDTH{1'b0}}, b_abs};
              opb <= a_abs;
            end else begin
              acc <= {{WIDTH{1'b0}}, a_abs};
              opb <= b_abs;
            end
            if (op == OP_MTHI) hi_q <= a;
            if (op == OP_MTLO) lo_q <= a;
          end
        end
        S_CALC: begin
          acc <= op_mul_q ? mul_nx : div_nx;
          cnt <= cnt - CW'(1);
        end
        S_FIXUP: begin
          hi_q <= fix_hi;
          lo_q <= fix_lo;
        end
        S_DONE:  dbz_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign ready       = (state == S_IDLE);
  assign done        = (state == S_DONE);
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv_seq.sv
// Bench for mips_cpu_muldiv_seq at three parameter points.
// Directed vector table, corner sequences, random vs. model.
import mips_cpu_muldiv_pkg::*;

module tb_mips_cpu_muldiv_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start_v [3];
  muldiv_op_t  op_v    [3];
  logic [31:0] a_v     [3];
  logic [31:0] b_v     [3];
  logic        ready_v [3];
  logic        done_v  [3];
  logic        dbz_v   [3];
  logic [31:0] hi_v    [3];
  logic [31:0] lo_v    [3];
  logic [31:0] hi0, lo0, hi1, lo1;
  logic [15:0] hi2, lo2;

  mips_cpu_muldiv_seq #(.WIDTH(32), .STEP(1)) u0 (
    .clk(clk), .reset(reset), .start(start_v[0]),
    .op(op_v[0]), .a(a_v[0]), .b(b_v[0]),
    .ready(ready_v[0]), .done(done_v[0]),
    .div_by_zero(dbz_v[0]), .hi(hi0), .lo(lo0));

  mips_cpu_muldiv_seq #(.WIDTH(32), .STEP(4)) u1 (
    .clk(clk), .reset(reset), .start(start_v[1]),
    .op(op_v[1]), .a(a_v[1]), .b(b_v[1]),
    .ready(ready_v[1]), .done(done_v[1]),
    .div_by_zero(dbz_v[1]), .hi(hi1), .lo(lo1));

  mips_cpu_muldiv_seq #(.WIDTH(16), .STEP(1)) u2 (
    .clk(clk), .reset(reset), .start(start_v[2]),
    .op(op_v[2]), .a(a_v[2][15:0]), .b(b_v[2][15:0]),
    .ready(ready_v[2]), .done(done_v[2]),
    .div_by_zero(dbz_v[2]), .hi(hi2), .lo(lo2));

  always_comb begin
    hi_v[0] = hi0;
    lo_v[0] = lo0;
    hi_v[1] = hi1;
    lo_v[1] = lo1;
    hi_v[2] = {16'h0, hi2};
    lo_v[2] = {16'h0, lo2};
  end

  int n_tests = 0;
  int n_fail  = 0;
  int w_of [3] = '{32, 32, 16};
  int s_of [3] = '{1, 4, 1};
  logic [31:0] m_hi [3];
  logic [31:0] m_lo [3];

  typedef struct {
    int          idx;
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
    bit          hold;
  } vec_t;

  vec_t tv [16];

  function automatic vec_t mk(
    int i, muldiv_op_t o, logic [31:0] av, bv,
    logic [31:0] h, l, logic z, int c, bit hd);
    vec_t v;
    v.idx = i; v.op = o; v.a = av; v.b = bv;
    v.hi = h; v.lo = l; v.dbz = z; v.cyc = c;
    v.hold = hd;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Architectural result from plain integer arithmetic.
  task automatic model(input int idx, input muldiv_op_t o,
                       input logic [31:0] av, bv,
                       output logic md);
    int          w;
    logic [63:0] mask, ua, ub, t;
    longint      sa, sb, sp, sq, sr;
    w    = w_of[idx];
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'h0, av} & mask;
    ub   = {32'h0, bv} & mask;
    sa   = ua[w-1] ? longint'(ua) - longint'(64'd1 << w)
                   : longint'(ua);
    sb   = ub[w-1] ? longint'(ub) - longint'(64'd1 << w)
                   : longint'(ub);
    md   = 1'b0;
    case (o)
      OP_MULT: begin
        sp = sa * sb; t = sp;
        m_hi[idx] = 32'((t >> w) & mask);
        m_lo[idx] = 32'(t & mask);
      end
      OP_MULTU: begin
        t = ua * ub;
        m_hi[idx] = 32'((t >> w) & mask);
        m_lo[idx] = 32'(t & mask);
      end
      OP_DIV: begin
        if (ub == 0) md = 1'b1;
        else begin
          sq = sa / sb; sr = sa % sb;
          t = sq; m_lo[idx] = 32'(t & mask);
          t = sr; m_hi[idx] = 32'(t & mask);
        end
      end
      OP_DIVU: begin
        if (ub == 0) md = 1'b1;
        else begin
          m_lo[idx] = 32'(ua / ub);
          m_hi[idx] = 32'(ua % ub);
        end
      end
      OP_MTHI: m_hi[idx] = 32'(ua);
      OP_MTLO: m_lo[idx] = 32'(ua);
      default: ;
    endcase
  endtask

  // Issue one op, wait for done, check pulse and ready return.
  task automatic run_op(input int idx, input muldiv_op_t o,
                        input logic [31:0] av, bv,
                        input bit hold,
                        output logic [31:0] rhi, rlo,
                        output logic rdbz, output int cyc);
    int          g;
    logic [31:0] pre_hi, pre_lo;
    bit          arith;
    g = 0;
    while (!ready_v[idx] && g < 100) begin
      @(negedge clk); g++;
    end
    chk("ready_before_start", 64'(ready_v[idx]), 64'd1);
    arith  = (o == OP_MULT) || (o == OP_MULTU)
          || (((o == OP_DIV) || (o == OP_DIVU)) && bv != 0);
    pre_hi = hi_v[idx];
    pre_lo = lo_v[idx];
    start_v[idx] = 1'b1;
    op_v[idx]    = o;
    a_v[idx]     = av;
    b_v[idx]     = bv;
    @(negedge clk);
    cyc = 1;
    if (!hold) start_v[idx] = 1'b0;
    op_v[idx] = muldiv_op_t'($urandom_range(0, 5));
    a_v[idx]  = $urandom;
    b_v[idx]  = $urandom;
    while (!done_v[idx] && cyc < 200) begin
      @(negedge clk); cyc++;
      if (cyc == 2 && arith) begin
        chk("hilo_hold_in_calc",
            {hi_v[idx], lo_v[idx]}, {pre_hi, pre_lo});
      end
    end
    chk("done_seen", 64'(done_v[idx]), 64'd1);
    rhi  = hi_v[idx];
    rlo  = lo_v[idx];
    rdbz = dbz_v[idx];
    start_v[idx] = 1'b0;
    @(negedge clk);
    chk("done_pulse_ready",
        {62'd0, done_v[idx], ready_v[idx]}, 64'd1);
    chk("dbz_cleared", 64'(dbz_v[idx]), 64'd0);
  endtask

  logic [31:0] rh, rl;
  logic        rz, mz;
  int          cyc, dcount;

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0; op_v[i] = OP_MULT;
      a_v[i] = '0; b_v[i] = '0;
      m_hi[i] = '0; m_lo[i] = '0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("reset_state",
          {ready_v[i], done_v[i], dbz_v[i], 29'd0,
           hi_v[i] | lo_v[i]},
          {1'b1, 63'd0});
    end

    tv[0]  = mk(0, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFFE, 32'h00000001, 0, 34, 0);
    tv[1]  = mk(0, OP_MULT, 32'hFFFFFFFD, 32'h5,
                32'hFFFFFFFF, 32'hFFFFFFF1, 0, 34, 0);
    tv[2]  = mk(0, OP_DIV, 32'hFFFFFFF9, 32'h2,
                32'hFFFFFFFF, 32'hFFFFFFFD, 0, 34, 0);
    tv[3]  = mk(0, OP_MTHI, 32'h11, 32'h0,
                32'h11, 32'hFFFFFFFD, 0, 1, 0);
    tv[4]  = mk(0, OP_MTLO, 32'h22, 32'h0,
                32'h11, 32'h22, 0, 1, 0);
    tv[5]  = mk(0, OP_DIVU, 32'h7, 32'h0,
                32'h11, 32'h22, 1, 1, 0);
    tv[6]  = mk(0, OP_DIV, 32'h80000000, 32'hFFFFFFFF,
                32'h0, 32'h80000000, 0, 34, 1);
    tv[7]  = mk(1, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFFE, 32'h00000001, 0, 10, 0);
    tv[8]  = mk(1, OP_MULT, 32'hFFFFFFFD, 32'h5,
                32'hFFFFFFFF, 32'hFFFFFFF1, 0, 10, 0);
    tv[9]  = mk(1, OP_DIV, 32'hFFFFFFF9, 32'h2,
                32'hFFFFFFFF, 32'hFFFFFFFD, 0, 10, 0);
    tv[10] = mk(1, OP_DIVU, 32'd100, 32'd7,
                32'd2, 32'd14, 0, 10, 0);
    tv[11] = mk(2, OP_MULTU, 32'hFFFF, 32'hFFFF,
                32'hFFFE, 32'h0001, 0, 18, 0);
    tv[12] = mk(2, OP_MULT, 32'hFFFD, 32'h5,
                32'hFFFF, 32'hFFF1, 0, 18, 0);
    tv[13] = mk(2, OP_DIV, 32'hFFF9, 32'h2,
                32'hFFFF, 32'hFFFD, 0, 18, 0);
    tv[14] = mk(2, OP_DIV, 32'h8000, 32'hFFFF,
                32'h0, 32'h8000, 0, 18, 1);
    tv[15] = mk(2, OP_DIVU, 32'h7, 32'h0,
                32'h0, 32'h8000, 1, 1, 0);

    foreach (tv[k]) begin
      run_op(tv[k].idx, tv[k].op, tv[k].a, tv[k].b,
             tv[k].hold, rh, rl, rz, cyc);
      chk($sformatf("vec%0d_hi", k), 64'(rh), 64'(tv[k].hi));
      chk($sformatf("vec%0d_lo", k), 64'(rl), 64'(tv[k].lo));
      chk($sformatf("vec%0d_dbz", k), 64'(rz), 64'(tv[k].dbz));
      chk($sformatf("vec%0d_cyc", k), 64'(cyc), 64'(tv[k].cyc));
      m_hi[tv[k].idx] = tv[k].hi;
      m_lo[tv[k].idx] = tv[k].lo;
    end

    for (int k = 0; k < 60; k++) begin
      int          idx, ecyc;
      muldiv_op_t  o;
      logic [31:0] av, bv;
      idx = k % 3;
      o   = muldiv_op_t'($urandom_range(0, 5));
      av  = $urandom;
      bv  = $urandom;
      case ($urandom_range(0, 7))
        0: bv = 32'h0;
        1: bv = $urandom_range(1, 9);
        2: av = 32'h80000000 >> (32 - w_of[idx]);
        3: bv = 32'hFFFFFFFF;
        default: ;
      endcase
      model(idx, o, av, bv, mz);
      ecyc = ((o == OP_MTHI) || (o == OP_MTLO) || mz)
           ? 1 : w_of[idx] / s_of[idx] + 2;
      run_op(idx, o, av, bv, 1'($urandom_range(0, 1)),
             rh, rl, rz, cyc);
      chk($sformatf("rnd%0d_op%0d_hi", k, o), 64'(rh),
          64'(m_hi[idx]));
      chk($sformatf("rnd%0d_op%0d_lo", k, o), 64'(rl),
          64'(m_lo[idx]));
      chk($sformatf("rnd%0d_dbz", k), 64'(rz), 64'(mz));
      chk($sformatf("rnd%0d_cyc", k), 64'(cyc), 64'(ecyc));
    end

    run_op(0, OP_MTHI, 32'hABCD1234, 32'h0, 0,
           rh, rl, rz, cyc);
    chk("pre_reset_hi", 64'(rh), 64'hABCD1234);
    start_v[0] = 1'b1;
    op_v[0]    = OP_DIVU;
    a_v[0]     = 32'hDEADBEEF;
    b_v[0]     = 32'd3;
    @(negedge clk);
    start_v[0] = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      @(negedge clk); cyc++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_mid_calc",
        {ready_v[0], done_v[0], 30'd0, hi_v[0] | lo_v[0]},
        {1'b1, 63'd0});
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_v[0]) dcount++;
    end
    chk("no_done_after_reset", 64'(dcount), 64'd0);
    chk("hilo_after_reset", {hi_v[0], lo_v[0]}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
